// File: rtl/lbfgs_history_mem.sv
// lbfgs_history_mem: circular store of the last NUM_LOOP (s, y, rho) triples, replayed
// newest->oldest then oldest->newest on three independent one-cycle-latency read streams.
module lbfgs_history_mem #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_ELEMENTS = 50,
    parameter int NUM_LOOP     = 10
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wr_en,
    input  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  s_in,
    input  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  y_in,
    input  logic [DATA_WIDTH-1:0]                    rho_in,
    input  logic                                     rd_start,
    input  logic                                     s_rd_en,
    input  logic                                     y_rd_en,
    input  logic                                     rho_rd_en,
    output logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  s,
    output logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  y,
    output logic [DATA_WIDTH-1:0]                    rho,
    output logic                                     s_valid,
    output logic                                     y_valid,
    output logic                                     rho_valid,
    output logic [$clog2(NUM_LOOP+1)-1:0]            num_stored,
    output logic                                     full,
    output logic                                     busy,
    output logic                                     err
);
    localparam int CW = $clog2(NUM_LOOP + 1);
    localparam int HW = NUM_LOOP > 1 ? $clog2(NUM_LOOP) : 1;
    localparam int JW = CW + 1;

    typedef logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] vec_t;

    vec_t                  s_mem   [NUM_LOOP];
    vec_t                  y_mem   [NUM_LOOP];
    logic [DATA_WIDTH-1:0] rho_mem [NUM_LOOP];

    logic [HW-1:0] head, head_nx, h_r;
    logic [CW-1:0] num_nx, m_r;
    logic [JW-1:0] cur [3];
    logic [JW-1:0] last;
    logic [HW-1:0] slot [3];
    logic [2:0]    rd, ok;
    logic          wr_ok, drop;

    // Slot for sequence index j of the pass snapshot (H = h_r, M = m_r); bias by NUM_LOOP keeps it non-negative.
    function automatic logic [HW-1:0] slot_of(input logic [JW-1:0] j, input logic [HW-1:0] h,
                                              input logic [CW-1:0] m);
        int x;
        x = int'(h) + NUM_LOOP + (int'(j) < int'(m) ? -1 - int'(j) : int'(j) - 2 * int'(m));
        return HW'(x >= NUM_LOOP ? x - NUM_LOOP : x);
    endfunction

    assign rd      = {rho_rd_en, y_rd_en, s_rd_en};
    assign wr_ok   = wr_en && !busy;
    assign drop    = wr_en && busy;
    assign head_nx = wr_ok ? (head == HW'(NUM_LOOP - 1) ? '0 : head + 1'b1) : head;
    assign num_nx  = (wr_ok && num_stored != CW'(NUM_LOOP)) ? num_stored + 1'b1 : num_stored;
    assign last    = {m_r, 1'b0};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            slot[i] = slot_of(cur[i], h_r, m_r);
            ok[i]   = busy && cur[i] != last;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            s_mem[head]   <= s_in;
            y_mem[head]   <= y_in;
            rho_mem[head] <= rho_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= '0;
            num_stored <= '0;
            full       <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            h_r        <= '0;
            m_r        <= '0;
            cur        <= '{default: '0};
            s          <= '0;
            y          <= '0;
            rho        <= '0;
            s_valid    <= 1'b0;
            y_valid    <= 1'b0;
            rho_valid  <= 1'b0;
        end else begin
            head       <= head_nx;
            num_stored <= num_nx;
            full       <= num_nx == CW'(NUM_LOOP);
            s_valid    <= s_rd_en;
            y_valid    <= y_rd_en;
            rho_valid  <= rho_rd_en;
            if (s_rd_en) s <= ok[0] ? s_mem[slot[0]] : '0;
            if (y_rd_en) y <= ok[1] ? y_mem[slot[1]] : '0;
            if (rho_rd_en) rho <= ok[2] ? rho_mem[slot[2]] : '0;
            for (int i = 0; i < 3; i++)
                if (rd_start) cur[i] <= '0;
                else if (rd[i] && ok[i]) cur[i] <= cur[i] + 1'b1;
            if (rd_start) begin
                h_r  <= head_nx;
                m_r  <= num_nx;
                busy <= num_nx != '0;
                err  <= drop;
            end else begin
                busy <= busy && !(cur[0] == last && cur[1] == last && cur[2] == last);
                err  <= err | drop | |(rd & ~ok);
            end
        end
    end
endmodule
